port_pkt_top: RTL and testbench

Packet-aware, parametrised switch output port: a store-and-forward successor to the word-level port. It filters incoming frames by destination address with optional broadcast, checks the length field and free space, and stores whole packets only. Truncated or oversize packets are rolled back, and dropped packets are counted. The read side exposes only committed packets, with start-of-packet and end-of-packet markers. It sits between the switch ingress bus and one egress consumer.

---
 rtl/port_pkt_pkg.sv | 27 ++
 rtl/port_pkt_top_fifo.sv | 72 +++++++
 rtl/port_pkt_top.sv | 174 +++++++++++++++++
 tb/tb_port_pkt_top.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/port_pkt_pkg.sv
// Shared types and helpers for the packet-aware switch output port.
package port_pkt_pkg;

    // Write-side framing states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2,
        DISCARD = 2'd3
    } wr_state_t;

    // Smallest storable packet: DST, L and one payload word.
    localparam int MIN_PKT = 3;

    // True when the low 'width' bits of addr are all ones (broadcast address).
    function automatic logic is_bcast(input logic [63:0] addr, input int width);
        logic r;
        r = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i < width) begin
                r = r & addr[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/port_pkt_top_fifo.sv
// Packet FIFO: speculative write pointer, commit pointer and read pointer.
// Only words below the commit pointer are visible to the reader; rollback
// rewinds the write pointer to the last commit. First-word fall-through read
// is built from a registered read that always prefetches the next head word.
module pkt_fifo #(
    parameter int W_WIDTH    = 8,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [W_WIDTH-1:0]            wr_data,
    input  logic                          commit,
    input  logic                          rollback,
    input  logic                          rd_en,
    output logic [W_WIDTH-1:0]            rd_data,
    output logic                          rdy,
    output logic [$clog2(FIFO_DEPTH):0]   free
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [W_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]      rd_ptr_reg;
    logic [PW-1:0]      wr_ptr_reg;
    logic [PW-1:0]      cm_ptr_reg;
    logic [PW-1:0]      rd_ptr_next;
    logic [PW-1:0]      used;
    logic [W_WIDTH-1:0] rd_data_reg;
    logic               rd_fire;

    assign rdy         = (rd_ptr_reg != cm_ptr_reg);
    assign rd_fire     = rd_en & rdy;
    assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, rd_fire};
    assign used        = wr_ptr_reg - rd_ptr_reg;
    assign free        = PW'(FIFO_DEPTH) - used;
    assign rd_data     = rdy ? rd_data_reg : '0;

    // Storage array write port (no reset so it maps onto block RAM).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    // Pointer update and head-word prefetch; a same-edge write to the next
    // head address is forwarded so the prefetched word is never stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg  <= '0;
            wr_ptr_reg  <= '0;
            cm_ptr_reg  <= '0;
            rd_data_reg <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            if (rollback) begin
                wr_ptr_reg <= cm_ptr_reg;
            end else if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (commit) begin
                cm_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, wr_en};
            end
            if (wr_en && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0])) begin
                rd_data_reg <= wr_data;
            end else begin
                rd_data_reg <= mem[rd_ptr_next[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/port_pkt_top.sv
// Store-and-forward switch output port: address filter, length/space check,
// whole-packet commit with rollback, read-side SOP/EOP framing and counters.
module port_pkt_top
    import port_pkt_pkg::*;
#(
    parameter int W_WIDTH    = 8,
    parameter int FIFO_DEPTH = 64,
    parameter int BCAST_EN   = 1,
    parameter int MAX_LEN    = FIFO_DEPTH - 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sw_en,
    input  logic [W_WIDTH-1:0]          port_data,
    input  logic [W_WIDTH-1:0]          port_addr,
    output logic                        rd_out,
    input  logic                        port_rd,
    output logic [W_WIDTH-1:0]          port_out,
    output logic                        port_rdy,
    output logic                        port_sop,
    output logic                        port_eop,
    output logic [$clog2(FIFO_DEPTH):0] pkt_cnt,
    output logic [15:0]                 drop_cnt
);
    localparam int PW    = $clog2(FIFO_DEPTH) + 1;
    localparam int OFF_W = W_WIDTH + 1;

    wr_state_t           state_reg, state_next;
    logic [W_WIDTH-1:0]  rem_reg, rem_next;
    logic [OFF_W-1:0]    off_reg;
    logic [W_WIDTH-1:0]  len_reg;
    logic [PW-1:0]       pkt_cnt_reg;
    logic [15:0]         drop_cnt_reg;
    logic [PW-1:0]       free;
    logic [31:0]         free32;
    logic [31:0]         len32;
    logic                wr_en, commit, rollback, drop_evt;
    logic                dst_match, pop, eop_pop;

    pkt_fifo #(
        .W_WIDTH    (W_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (port_data),
        .commit   (commit),
        .rollback (rollback),
        .rd_en    (port_rd),
        .rd_data  (port_out),
        .rdy      (port_rdy),
        .free     (free)
    );

    assign free32    = 32'(free);
    assign len32     = 32'(port_data);
    assign dst_match = (port_data == port_addr) ||
                       ((BCAST_EN != 0) &&
                        is_bcast({{(64-W_WIDTH){1'b0}}, port_data}, W_WIDTH));
    assign rd_out    = (state_reg == IDLE) && (free32 >= 32'(MIN_PKT));

    // Write FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            rem_reg   <= '0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
        end
    end

    // Write FSM next state: filter, length/space check, commit and rollback.
    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        wr_en      = 1'b0;
        commit     = 1'b0;
        rollback   = 1'b0;
        drop_evt   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sw_en) begin
                    if (!dst_match) begin
                        state_next = DISCARD;
                    end else if (free32 >= 32'(MIN_PKT)) begin
                        wr_en      = 1'b1;
                        state_next = LEN;
                    end else begin
                        drop_evt   = 1'b1;
                        state_next = DISCARD;
                    end
                end
            end
            LEN: begin
                if (!sw_en) begin
                    rollback   = 1'b1;
                    drop_evt   = 1'b1;
                    state_next = IDLE;
                end else if ((len32 == 32'd0) || (len32 > 32'(MAX_LEN)) ||
                             (free32 < len32 + 32'd1)) begin
                    rollback   = 1'b1;
                    drop_evt   = 1'b1;
                    state_next = DISCARD;
                end else begin
                    wr_en      = 1'b1;
                    rem_next   = port_data;
                    state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!sw_en) begin
                    rollback   = 1'b1;
                    drop_evt   = 1'b1;
                    state_next = IDLE;
                end else begin
                    wr_en    = 1'b1;
                    rem_next = rem_reg - W_WIDTH'(1);
                    if (rem_reg == W_WIDTH'(1)) begin
                        commit     = 1'b1;
                        state_next = DISCARD;
                    end
                end
            end
            DISCARD: begin
                if (!sw_en) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign pop      = port_rd & port_rdy;
    assign port_sop = port_rdy && (off_reg == '0);
    assign port_eop = port_rdy && (off_reg >= OFF_W'(2)) &&
                      (off_reg == {1'b0, len_reg} + OFF_W'(1));
    assign eop_pop  = pop & port_eop;

    // Read-side framing: word offset within the head packet and its length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            off_reg <= '0;
            len_reg <= '0;
        end else if (pop) begin
            off_reg <= port_eop ? '0 : off_reg + OFF_W'(1);
            if (off_reg == OFF_W'(1)) begin
                len_reg <= port_out;
            end
        end
    end

    // Committed-packet and saturating drop counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt_reg  <= '0;
            drop_cnt_reg <= '0;
        end else begin
            if (commit && !eop_pop) begin
                pkt_cnt_reg <= pkt_cnt_reg + PW'(1);
            end else if (!commit && eop_pop) begin
                pkt_cnt_reg <= pkt_cnt_reg - PW'(1);
            end
            if (drop_evt && (drop_cnt_reg != 16'hFFFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
        end
    end

    assign pkt_cnt  = pkt_cnt_reg;
    assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_port_pkt_top.sv
// Directed, table-driven bench for port_pkt_top (W_WIDTH=8, FIFO_DEPTH=16).
module tb_port_pkt_top;
    logic        clk = 1'b0;
    logic        rst;
    logic        sw_en;
    logic        port_rd;
    logic [7:0]  port_data;
    logic [7:0]  port_addr;
    logic        rd_out, port_rdy, port_sop, port_eop;
    logic [7:0]  port_out;
    logic [4:0]  pkt_cnt;
    logic [15:0] drop_cnt;
    logic        nb_rd_out, nb_rdy, nb_sop, nb_eop;
    logic [7:0]  nb_out;
    logic [4:0]  nb_pkt_cnt;
    logic [15:0] nb_drop_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    port_pkt_top #(.W_WIDTH(8), .FIFO_DEPTH(16), .BCAST_EN(1)) dut (
        .clk(clk), .rst(rst), .sw_en(sw_en), .port_data(port_data),
        .port_addr(port_addr), .rd_out(rd_out), .port_rd(port_rd),
        .port_out(port_out), .port_rdy(port_rdy), .port_sop(port_sop),
        .port_eop(port_eop), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    // Same stimulus, broadcast disabled.
    port_pkt_top #(.W_WIDTH(8), .FIFO_DEPTH(16), .BCAST_EN(0)) dut_nb (
        .clk(clk), .rst(rst), .sw_en(sw_en), .port_data(port_data),
        .port_addr(port_addr), .rd_out(nb_rd_out), .port_rd(port_rd),
        .port_out(nb_out), .port_rdy(nb_rdy), .port_sop(nb_sop),
        .port_eop(nb_eop), .pkt_cnt(nb_pkt_cnt), .drop_cnt(nb_drop_cnt)
    );

    typedef struct {
        logic        sw;
        logic [7:0]  d;
        logic        rd;
        logic        e_rdy;
        logic [7:0]  e_out;
        logic        e_sop;
        logic        e_eop;
        logic [4:0]  e_pkt;
        logic [15:0] e_drop;
        logic        e_rdo;
        logic        nb;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic sw, input logic [7:0] d, input logic rd,
                       input logic rdy, input logic [7:0] out, input logic sop,
                       input logic eop, input logic [4:0] pkt, input logic [15:0] drop,
                       input logic rdo, input logic nb = 1'b0);
        vec_t v;
        v.sw = sw; v.d = d; v.rd = rd; v.e_rdy = rdy; v.e_out = out;
        v.e_sop = sop; v.e_eop = eop; v.e_pkt = pkt; v.e_drop = drop;
        v.e_rdo = rdo; v.nb = nb;
        vq.push_back(v);
    endtask

    // Idle row: no write, no read, queue empty.
    task automatic add_empty(input logic sw, input logic [7:0] d,
                             input logic [15:0] drop, input logic rdo, input logic nb = 1'b0);
        add(sw, d, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, drop, rdo, nb);
    endtask

    task automatic run_vectors(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            sw_en = vq[i].sw; port_data = vq[i].d; port_rd = vq[i].rd;
            @(posedge clk);
            #1;
            $display("%s[%0d] sw=%b d=%h rd=%b -> rdy=%b out=%h sop=%b eop=%b pkt=%0d drop=%0d rd_out=%b",
                     tag, i, vq[i].sw, vq[i].d, vq[i].rd, port_rdy, port_out,
                     port_sop, port_eop, pkt_cnt, drop_cnt, rd_out);
            chk($sformatf("%s[%0d].rdy", tag, i), 32'(port_rdy), 32'(vq[i].e_rdy));
            chk($sformatf("%s[%0d].out", tag, i), 32'(port_out), 32'(vq[i].e_out));
            chk($sformatf("%s[%0d].sop", tag, i), 32'(port_sop), 32'(vq[i].e_sop));
            chk($sformatf("%s[%0d].eop", tag, i), 32'(port_eop), 32'(vq[i].e_eop));
            chk($sformatf("%s[%0d].pkt", tag, i), 32'(pkt_cnt), 32'(vq[i].e_pkt));
            chk($sformatf("%s[%0d].drop", tag, i), 32'(drop_cnt), 32'(vq[i].e_drop));
            chk($sformatf("%s[%0d].rd_out", tag, i), 32'(rd_out), 32'(vq[i].e_rdo));
            if (vq[i].nb) begin
                chk($sformatf("%s[%0d].nb_rdy", tag, i), 32'(nb_rdy), 32'd0);
                chk($sformatf("%s[%0d].nb_pkt", tag, i), 32'(nb_pkt_cnt), 32'd0);
            end
        end
        vq.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        $display("%s: rdy=%b out=%h sop=%b eop=%b pkt=%0d drop=%0d rd_out=%b",
                 tag, port_rdy, port_out, port_sop, port_eop, pkt_cnt, drop_cnt, rd_out);
        chk({tag, ".rdy"},    32'(port_rdy), 32'd0);
        chk({tag, ".out"},    32'(port_out), 32'd0);
        chk({tag, ".sop"},    32'(port_sop), 32'd0);
        chk({tag, ".eop"},    32'(port_eop), 32'd0);
        chk({tag, ".pkt"},    32'(pkt_cnt),  32'd0);
        chk({tag, ".drop"},   32'(drop_cnt), 32'd0);
        chk({tag, ".rd_out"}, 32'(rd_out),   32'd1);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; sw_en = 1'b0; port_rd = 1'b0; port_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs(tag);
        rst = 1'b0;
    endtask

    logic [7:0] words [16];

    initial begin
        port_addr = 8'h05;
        do_reset("reset0");

        // Basic frame and full read-back.
        add_empty(1'b1, 8'h05, 16'd0, 1'b0);
        add_empty(1'b1, 8'h03, 16'd0, 1'b0);
        add_empty(1'b1, 8'hAA, 16'd0, 1'b0);
        add_empty(1'b1, 8'hBB, 16'd0, 1'b0);
        add(1'b1, 8'hCC, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 5'd1, 16'd0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 5'd1, 16'd0, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 5'd1, 16'd0, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b1, 8'hBB, 1'b0, 1'b0, 5'd1, 16'd0, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b1, 8'hCC, 1'b0, 1'b1, 5'd1, 16'd0, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 16'd0, 1'b1);
        // Foreign address: discarded, not a drop.
        add_empty(1'b1, 8'h07, 16'd0, 1'b0);
        add_empty(1'b1, 8'h02, 16'd0, 1'b0);
        add_empty(1'b1, 8'h11, 16'd0, 1'b0);
        add_empty(1'b1, 8'h22, 16'd0, 1'b0);
        add_empty(1'b0, 8'h00, 16'd0, 1'b1);
        // Broadcast: stored here, ignored by the non-broadcast instance.
        add_empty(1'b1, 8'hFF, 16'd0, 1'b0);
        add_empty(1'b1, 8'h01, 16'd0, 1'b0);
        add(1'b1, 8'h33, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 5'd1, 16'd0, 1'b0, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 5'd1, 16'd0, 1'b1, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 5'd1, 16'd0, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 5'd1, 16'd0, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 16'd0, 1'b1);
        run_vectors("basic");

        do_reset("reset1");

        // Truncated frame rolled back, then next frame stored from address 0.
        add_empty(1'b1, 8'h05, 16'd0, 1'b0);
        add_empty(1'b1, 8'h04, 16'd0, 1'b0);
        add_empty(1'b1, 8'h11, 16'd0, 1'b0);
        add_empty(1'b1, 8'h22, 16'd0, 1'b0);
        add_empty(1'b0, 8'h00, 16'd1, 1'b1);
        add_empty(1'b1, 8'h05, 16'd1, 1'b0);
        add_empty(1'b1, 8'h01, 16'd1, 1'b0);
        add(1'b1, 8'h99, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 5'd1, 16'd1, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 5'd1, 16'd1, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b1, 8'h99, 1'b0, 1'b1, 5'd1, 16'd1, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 16'd1, 1'b1);
        // 12-word packet leaves free=4; a 7-word packet is dropped at L.
        add_empty(1'b1, 8'h05, 16'd1, 1'b0);
        add_empty(1'b1, 8'h0A, 16'd1, 1'b0);
        for (int i = 0; i < 9; i++) add_empty(1'b1, 8'h40 + 8'(i), 16'd1, 1'b0);
        add(1'b1, 8'h49, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 5'd1, 16'd1, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 5'd1, 16'd1, 1'b1);
        add(1'b1, 8'h05, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 5'd1, 16'd1, 1'b0);
        add(1'b1, 8'h05, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 5'd1, 16'd2, 1'b0);
        add(1'b1, 8'h01, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 5'd1, 16'd2, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 5'd1, 16'd2, 1'b1);
        // 4-word packet exactly fills the FIFO.
        add(1'b1, 8'h05, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 5'd1, 16'd2, 1'b0);
        add(1'b1, 8'h02, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 5'd1, 16'd2, 1'b0);
        add(1'b1, 8'hA1, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 5'd1, 16'd2, 1'b0);
        add(1'b1, 8'hA2, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 5'd2, 16'd2, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 5'd2, 16'd2, 1'b0);
        // Drain all 16 words; rd_out returns once free reaches 3.
        words[0] = 8'h05; words[1] = 8'h0A;
        for (int i = 0; i < 10; i++) words[2+i] = 8'h40 + 8'(i);
        words[12] = 8'h05; words[13] = 8'h02; words[14] = 8'hA1; words[15] = 8'hA2;
        for (int k = 0; k < 15; k++) begin
            add(1'b0, 8'h00, 1'b1, 1'b1, words[k+1], (k+1 == 12), (k+1 == 11) || (k+1 == 15),
                (k >= 11) ? 5'd1 : 5'd2, 16'd2, (k+1 >= 3));
        end
        add_empty(1'b0, 8'h00, 16'd2, 1'b1);
        vq[vq.size()-1].rd = 1'b1;
        // L=0 and L>MAX_LEN are dropped.
        add_empty(1'b1, 8'h05, 16'd2, 1'b0);
        add_empty(1'b1, 8'h00, 16'd3, 1'b0);
        add_empty(1'b0, 8'h00, 16'd3, 1'b1);
        add_empty(1'b1, 8'h05, 16'd3, 1'b0);
        add_empty(1'b1, 8'h0F, 16'd4, 1'b0);
        add_empty(1'b1, 8'h12, 16'd4, 1'b0);
        add_empty(1'b0, 8'h00, 16'd4, 1'b1);
        // EOP pop of packet 1 on the commit edge of packet 2.
        add_empty(1'b1, 8'h05, 16'd4, 1'b0);
        add_empty(1'b1, 8'h01, 16'd4, 1'b0);
        add(1'b1, 8'h11, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 5'd1, 16'd4, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 5'd1, 16'd4, 1'b1);
        add(1'b1, 8'h05, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 5'd1, 16'd4, 1'b0);
        add(1'b1, 8'h02, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 5'd1, 16'd4, 1'b0);
        add(1'b1, 8'h21, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 5'd1, 16'd4, 1'b0);
        add(1'b1, 8'h22, 1'b1, 1'b1, 8'h05, 1'b1, 1'b0, 5'd1, 16'd4, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 5'd1, 16'd4, 1'b1);
        // Packet 3 in flight (mid-PAYLOAD) for the asynchronous reset check.
        add(1'b1, 8'h05, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 5'd1, 16'd4, 1'b0);
        add(1'b1, 8'h03, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 5'd1, 16'd4, 1'b0);
        add(1'b1, 8'h31, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 5'd1, 16'd4, 1'b0);
        run_vectors("pkt");

        // Asynchronous reset mid-PAYLOAD, observed before the next clock edge.
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        sw_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
